// File: rtl/cs161_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// cs161_hazard_ctrl
//
// Decode and issue control for a 5-stage datapath that has no forwarding.
// The block decodes the IF/ID instruction word into datapath controls and
// tracks the destinations of the three instructions ahead of it (ID/EX,
// EX/MEM, MEM/WB). It inserts bubbles and freezes PC and IF/ID on RAW hazards
// and for the shadow of a beq.
//
// Parameters:
//   WB_SAME_CYCLE - 1: register file writes before reads in the same cycle,
//                   so the MEM/WB entry is not a hazard source.
//   BR_SHADOW     - bubble cycles after a beq issues (must be >= 1).
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   instr           IF/ID instruction word
//   instr_valid     instr holds a real instruction (0 = NOP)
//   reg_dst, branch, mem_read, mem_to_reg, alu_op[3:0], mem_write,
//   alu_src, reg_write
//                   datapath controls (all zero when bubble=1)
//   pc_write        1 = PC may advance
//   ifid_write      1 = IF/ID may load
//   bubble          controls forced to zero this cycle
//   illegal_op      sticky flag, valid instruction with unknown opcode
//   state           debug: 0 RUN, 1 RAW_STALL, 2 BR_WAIT
//
// Optional feature (macro CS161_HAZ_STATS_EN):
//   stall_cycles[15:0]  saturating count of RAW_STALL cycles
//   branch_cycles[15:0] saturating count of BR_WAIT cycles
// -----------------------------------------------------------------------------
module cs161_hazard_ctrl #(
    parameter int WB_SAME_CYCLE = 1,
    parameter int BR_SHADOW     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        reg_dst,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_to_reg,
    output logic [3:0]  alu_op,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        bubble,
    output logic        illegal_op,
    output logic [1:0]  state
`ifdef CS161_HAZ_STATS_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] branch_cycles
`endif
);

    localparam int CNT_W = (BR_SHADOW < 2) ? 1 : $clog2(BR_SHADOW + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_RAW_STALL = 2'd1,
        ST_BR_WAIT   = 2'd2
    } state_e;

    typedef struct packed {
        logic       vld;
        logic [4:0] dst;
    } sb_entry_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic             illegal_q, illegal_d;
    sb_entry_t        sb_e_q, sb_m_q, sb_w_q, sb_e_d;

    // Instruction fields
    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    logic       unused_imm;

    assign opcode     = instr[31:26];
    assign rs         = instr[25:21];
    assign rt         = instr[20:16];
    assign rd         = instr[15:11];
    assign unused_imm = ^instr[10:0];

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    logic       dec_reg_dst, dec_branch, dec_mem_read, dec_mem_to_reg;
    logic       dec_mem_write, dec_alu_src, dec_reg_write;
    logic [3:0] dec_alu_op;
    logic       use_rs, use_rt, dec_known;
    logic [4:0] dec_dst;

    // NOTE: every signal driven here gets a default before the case, so no
    // path through the block leaves a value unassigned and no latch is built.
    always_comb begin
        dec_reg_dst    = 1'b0;
        dec_branch     = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_reg_write  = 1'b0;
        dec_alu_op     = 4'b0000;
        use_rs         = 1'b0;
        use_rt         = 1'b0;
        dec_dst        = 5'd0;
        dec_known      = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 4'b0010;
                use_rs        = 1'b1;
                use_rt        = 1'b1;
                dec_dst       = rd;
            end
            OP_LW: begin
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
                use_rs         = 1'b1;
                dec_dst        = rt;
            end
            OP_SW: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                use_rs        = 1'b1;
                use_rt        = 1'b1;
            end
            OP_BEQ: begin
                dec_branch = 1'b1;
                dec_alu_op = 4'b0001;
                use_rs     = 1'b1;
                use_rt     = 1'b1;
            end
            OP_ADDI: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                use_rs        = 1'b1;
                dec_dst       = rt;
            end
            default: dec_known = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Hazard detection against the scoreboard. $0 never matches because
    // entries are only made valid for nonzero destinations and sources of $0
    // are filtered out here as well.
    // -------------------------------------------------------------------------
    function automatic logic src_hit(input logic [4:0] r, input sb_entry_t e);
        return e.vld && (r != 5'd0) && (e.dst == r);
    endfunction

    logic hz_rs, hz_rt, hz;

    always_comb begin
        hz_rs = src_hit(rs, sb_e_q) || src_hit(rs, sb_m_q);
        hz_rt = src_hit(rt, sb_e_q) || src_hit(rt, sb_m_q);
        if (WB_SAME_CYCLE == 0) begin
            hz_rs = hz_rs || src_hit(rs, sb_w_q);
            hz_rt = hz_rt || src_hit(rt, sb_w_q);
        end
        hz = instr_valid && ((use_rs && hz_rs) || (use_rt && hz_rt));
    end

    // -------------------------------------------------------------------------
    // FSM next state and issue control
    // -------------------------------------------------------------------------
    logic issue;

    always_comb begin
        state_d    = state_q;
        br_cnt_d   = br_cnt_q;
        issue      = 1'b0;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        case (state_q)
            ST_RUN, ST_RAW_STALL: begin
                if (!instr_valid) begin
                    // Nothing to issue; keep fetching.
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    state_d    = ST_RUN;
                end else if (hz) begin
                    state_d = ST_RAW_STALL;
                end else begin
                    // A stalled instruction issues in the same cycle its
                    // hazard clears.
                    issue      = 1'b1;
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    if (dec_branch) begin
                        state_d  = ST_BR_WAIT;
                        br_cnt_d = CNT_W'(BR_SHADOW);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_BR_WAIT: begin
                if (br_cnt_q <= CNT_W'(1)) begin
                    // Last shadow cycle: load the resolved next PC.
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    br_cnt_d = br_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (rst) begin
            issue      = 1'b0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    // Illegal opcodes are flagged only when the word is actually being decoded,
    // not while a stale word sits in IF/ID during the branch shadow.
    logic illegal_now;

    assign illegal_now = instr_valid && !dec_known && (state_q != ST_BR_WAIT) && !rst;
    assign illegal_d   = illegal_q || illegal_now;

    always_comb begin
        sb_e_d.vld = issue && dec_reg_write && (dec_dst != 5'd0);
        sb_e_d.dst = sb_e_d.vld ? dec_dst : 5'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            br_cnt_q  <= '0;
            illegal_q <= 1'b0;
            sb_e_q    <= '0;
            sb_m_q    <= '0;
            sb_w_q    <= '0;
        end else begin
            state_q   <= state_d;
            br_cnt_q  <= br_cnt_d;
            illegal_q <= illegal_d;
            sb_e_q    <= sb_e_d;
            sb_m_q    <= sb_e_q;
            sb_w_q    <= sb_m_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign reg_dst    = issue && dec_reg_dst;
    assign branch     = issue && dec_branch;
    assign mem_read   = issue && dec_mem_read;
    assign mem_to_reg = issue && dec_mem_to_reg;
    assign alu_op     = issue ? dec_alu_op : 4'b0000;
    assign mem_write  = issue && dec_mem_write;
    assign alu_src    = issue && dec_alu_src;
    assign reg_write  = issue && dec_reg_write;
    assign bubble     = !issue;
    assign illegal_op = !rst && illegal_d;
    assign state      = state_q;

`ifdef CS161_HAZ_STATS_EN
    logic [15:0] stall_cnt_q, branch_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            branch_cnt_q <= '0;
        end else begin
            if (state_q == ST_RAW_STALL && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (state_q == ST_BR_WAIT && branch_cnt_q != 16'hFFFF)
                branch_cnt_q <= branch_cnt_q + 16'd1;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign branch_cycles = branch_cnt_q;
`endif

endmodule

// File: doc/cs161_hazard_ctrl.md
Name: cs161_hazard_ctrl

Overview:
- Decode and issue-control stage directly upstream of the 5-stage datapath.
- Consumes the IF/ID instruction word and drives every datapath control input: reg_dst, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write.
- The datapath has no forwarding, so this block keeps a 3-entry destination scoreboard (ID/EX, EX/MEM, MEM/WB). It inserts bubbles and freezes PC and IF/ID on RAW hazards and for the branch shadow.

Parameters:
- WB_SAME_CYCLE, 1, 1 = register file writes before read in the same cycle, so the MEM/WB scoreboard entry is not checked.
- BR_SHADOW, 3, bubble cycles after a beq issues, until the branch resolves in EX/MEM.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- instr  in  32  IF/ID instruction word
- instr_valid  in  1  instr holds a real instruction; 0 = treat as NOP
- reg_dst  out  1  datapath control
- branch  out  1  datapath control
- mem_read  out  1  datapath control
- mem_to_reg  out  1  datapath control
- alu_op  out  4  datapath control
- mem_write  out  1  datapath control
- alu_src  out  1  datapath control
- reg_write  out  1  datapath control
- pc_write  out  1  1 = PC may advance; 0 = hold
- ifid_write  out  1  1 = IF/ID may load; 0 = hold
- bubble  out  1  controls forced to zero this cycle
- illegal_op  out  1  sticky; set on a valid unknown opcode
- state  out  2  debug: 0 RUN, 1 RAW_STALL, 2 BR_WAIT

Behaviour:
- Reset (rst=1 at posedge): state=RUN, scoreboard invalid, br_cnt=0, illegal_op=0. Outputs during reset: all controls 0, bubble=1, pc_write=0, ifid_write=0.
- Decode (combinational from instr[31:26]):
  - 0x00 R-type: reg_dst=1, reg_write=1, alu_op=4'b0010; sources rs, rt; dst = rd.
  - 0x23 lw: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=4'b0000; source rs; dst = rt.
  - 0x2B sw: alu_src=1, mem_write=1, alu_op=4'b0000; sources rs, rt.
  - 0x04 beq: branch=1, alu_op=4'b0001; sources rs, rt.
  - 0x08 addi: alu_src=1, reg_write=1, alu_op=4'b0000; source rs; dst = rt.
  - Other opcode with instr_valid=1: decode as NOP and set illegal_op (sticky until rst).
- Register $0 is never a hazard source or destination.
- Hazard condition (hz): any used source equals the dst of a valid E or M entry. When WB_SAME_CYCLE=0, the W entry is also checked.
- Issue: instruction issues when state=RUN, hz=0 and instr_valid=1. On issue, controls = decode, bubble=0, pc_write=1, ifid_write=1.
- Not issuing: controls=0, bubble=1.
- Scoreboard, every cycle: W<=M, M<=E. E<={1,dst} if the issued instruction writes a nonzero reg, else invalid. A bubble shifts an invalid entry into E.
- FSM:
  - RUN:
    - hz=1 -> RAW_STALL (bubble now; pc_write=0, ifid_write=0).
    - Issuing beq -> BR_WAIT with br_cnt=BR_SHADOW; beq itself issues with pc_write=1.
    - Otherwise stay in RUN.
  - RAW_STALL: hold PC and IF/ID, bubble. Return to RUN the cycle hz evaluates 0; the instruction then issues that same cycle. Maximum 2 stall cycles (3 when WB_SAME_CYCLE=0).
  - BR_WAIT: bubble, pc_write=0, ifid_write=0; decrement br_cnt. At br_cnt==1, assert pc_write=1 and ifid_write=1 so the resolved next PC loads, then -> RUN.
- instr_valid=0 in RUN: bubble=1, pc_write=1, ifid_write=1 (fetch continues); state stays RUN.
- Back-to-back beq: the second beq is decoded only after return to RUN, with a normal hazard check.
- rst mid-stall or mid-branch wait: immediately RUN and all scoreboard entries cleared.

Optional Feature:
- Macro: CS161_HAZ_STATS_EN.
- When defined:
  - Extra outputs stall_cycles[15:0] and branch_cycles[15:0], both saturating at 16'hFFFF and cleared by rst.
  - stall_cycles increments per RAW_STALL cycle.
  - branch_cycles increments per BR_WAIT cycle.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then add $3,$1,$2 (0x00221820) valid -> cycle 1: reg_write=1, reg_dst=1, alu_op=0010, bubble=0, pc_write=1.
- lw $2,0($1) then add $3,$2,$4, WB_SAME_CYCLE=1 -> add stalls exactly 2 cycles (bubble=1, pc_write=0), then issues with reg_write=1.
- addi $0,$1,5 then add $3,$0,$0 -> no stall; E entry invalid.
- beq $1,$2,off, BR_SHADOW=3 -> beq issues with branch=1. Next 3 cycles bubble=1; pc_write=0,0,1; then RUN.
- Opcode 0x3F valid -> all controls 0 and illegal_op=1, held through following legal instructions until rst.
- rst asserted during the 2nd RAW_STALL cycle -> next cycle state=0, scoreboard empty; the held add issues immediately after rst deasserts.
